// File: rtl/sec_ctrl_pkg.sv
// rtl/sec_ctrl_pkg.sv - shared types and constants for the cache attack response controller
//
// Contents:
//   state_e        controller states MONITOR / FLUSH / COOLDOWN (2'b11 unused)
//   DEF_*          default threshold/window/index width shared with the monitor integration
//   num_lines()    number of cache lines walked for a given index width
package sec_ctrl_pkg;

    typedef enum logic [1:0] {
        MONITOR  = 2'b00,
        FLUSH    = 2'b01,
        COOLDOWN = 2'b10
    } state_e;

    localparam int DEF_THRESHOLD  = 4;
    localparam int DEF_WINDOW     = 1024;
    localparam int DEF_CACHE_ADDR = 7;

    function automatic int num_lines(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int NUM_LINES = num_lines(DEF_CACHE_ADDR);

endpackage

// File: rtl/sec_window_counter.sv
// rtl/sec_window_counter.sv - sliding cycle window with saturating per-window hit count
//
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   en            advance the window and accept hits (controller in MONITOR)
//   clr           force window counter and hit count to zero
//   irq           attack pulse for this cycle
//   trigger       combinational: this pulse brings the window's hit count to THRESHOLD
module sec_window_counter #(
    parameter int WINDOW    = 1024,
    parameter int THRESHOLD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic irq,
    output logic trigger
);

    localparam int WW = $clog2(WINDOW);
    localparam int HW = $clog2(THRESHOLD + 1);

    logic [WW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hits_q, hits_d;
    logic [HW-1:0] base;
    logic          wrap;

    always_comb begin
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        wrap    = en && (cnt_q == WW'(WINDOW - 1));
        // A pulse coinciding with the wrap belongs to the new window.
        base    = wrap ? '0 : hits_q;
        trigger = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            hits_d = '0;
        end else if (en) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            hits_d = base;
            if (irq) begin
                if (base < HW'(THRESHOLD)) begin
                    hits_d = base + 1'b1;
                end
                trigger = (int'(base) + 1 >= THRESHOLD);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            hits_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hits_q <= hits_d;
        end
    end

endmodule

// File: rtl/cache_attack_response_ctrl.sv
// rtl/cache_attack_response_ctrl.sv - attack-rate threshold, CPU stall and cache flush sequencer
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   irq_in         one-cycle attack pulse from the security monitor
//   attack_addr    cache index of the attacked line, valid with irq_in
//   clear_alarm    software clear of the sticky alarm (a same-cycle set wins)
//   flush_ack      cache controller accepts the current flush request
//   flush_req      flush request for flush_index
//   flush_index    line being flushed
//   cpu_stall      holds the CPU off the cache during a flush
//   alarm          sticky threshold-reached flag
//   attack_count   saturating total of attack pulses since reset
//   busy           high in FLUSH or COOLDOWN
//
// Build option: define SEC_TARGETED_FLUSH_EN to flush only the line named by the
// triggering pulse instead of walking every line.
module cache_attack_response_ctrl
    import sec_ctrl_pkg::*;
#(
    parameter int CACHE_ADDR   = DEF_CACHE_ADDR,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int COOLDOWN_CYC = 16,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  irq_in,
    input  logic [CACHE_ADDR-1:0] attack_addr,
    input  logic                  clear_alarm,
    input  logic                  flush_ack,
    output logic                  flush_req,
    output logic [CACHE_ADDR-1:0] flush_index,
    output logic                  cpu_stall,
    output logic                  alarm,
    output logic [CNT_W-1:0]      attack_count,
    output logic                  busy
);

    localparam int                  LINES     = num_lines(CACHE_ADDR);
    localparam logic [CACHE_ADDR-1:0] LAST_IDX = CACHE_ADDR'(LINES - 1);
    localparam int                  CCW       = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CCW-1:0]      LAST_COOL = CCW'(COOLDOWN_CYC - 1);

    state_e                state_q, state_d;
    logic                  irq_q, irq_d;
    logic                  flush_req_q, flush_req_d;
    logic [CACHE_ADDR-1:0] flush_index_q, flush_index_d;
    logic                  cpu_stall_q, cpu_stall_d;
    logic                  alarm_q, alarm_d;
    logic [CNT_W-1:0]      attack_count_q, attack_count_d;
    logic                  busy_q, busy_d;
    logic [CCW-1:0]        cool_cnt_q, cool_cnt_d;
    logic                  win_trigger;

`ifdef SEC_TARGETED_FLUSH_EN
    logic [CACHE_ADDR-1:0] addr_q, addr_d;
`else
    logic unused_attack_addr;
    assign unused_attack_addr = ^attack_addr;
`endif

    // The pulse is registered once before the window logic, so a pulse
    // sampled at edge N shows up on flush_req/cpu_stall after edge N+1.
    sec_window_counter #(
        .WINDOW    (WINDOW),
        .THRESHOLD (THRESHOLD)
    ) u_win (
        .clock   (clock),
        .reset   (reset),
        .en      (state_q == MONITOR),
        .clr     (state_q != MONITOR),
        .irq     (irq_q),
        .trigger (win_trigger)
    );

    always_comb begin
        state_d        = state_q;
        irq_d          = irq_in;
        flush_req_d    = flush_req_q;
        flush_index_d  = flush_index_q;
        cpu_stall_d    = cpu_stall_q;
        alarm_d        = alarm_q;
        attack_count_d = attack_count_q;
        busy_d         = busy_q;
        cool_cnt_d     = cool_cnt_q;
`ifdef SEC_TARGETED_FLUSH_EN
        addr_d         = addr_q;
        if (irq_in && state_q == MONITOR) begin
            addr_d = attack_addr;
        end
`endif

        if (irq_q && attack_count_q != {CNT_W{1'b1}}) begin
            attack_count_d = attack_count_q + 1'b1;
        end

        // Clear first so a threshold set in the same cycle overrides it.
        if (clear_alarm) begin
            alarm_d = 1'b0;
        end

        case (state_q)
            MONITOR: begin
                if (win_trigger) begin
                    state_d     = FLUSH;
                    alarm_d     = 1'b1;
                    flush_req_d = 1'b1;
                    cpu_stall_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef SEC_TARGETED_FLUSH_EN
                    flush_index_d = addr_q;
`else
                    flush_index_d = '0;
`endif
                end
            end
            FLUSH: begin
                if (flush_req_q && flush_ack) begin
`ifdef SEC_TARGETED_FLUSH_EN
                    if (1'b1) begin
`else
                    if (flush_index_q == LAST_IDX) begin
`endif
                        state_d       = COOLDOWN;
                        flush_req_d   = 1'b0;
                        cpu_stall_d   = 1'b0;
                        flush_index_d = '0;
                        cool_cnt_d    = '0;
                    end else begin
                        flush_index_d = flush_index_q + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (cool_cnt_q == LAST_COOL) begin
                    state_d    = MONITOR;
                    busy_d     = 1'b0;
                    cool_cnt_d = '0;
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d       = MONITOR;
                flush_req_d   = 1'b0;
                cpu_stall_d   = 1'b0;
                busy_d        = 1'b0;
                flush_index_d = '0;
                cool_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= MONITOR;
            irq_q          <= 1'b0;
            flush_req_q    <= 1'b0;
            flush_index_q  <= '0;
            cpu_stall_q    <= 1'b0;
            alarm_q        <= 1'b0;
            attack_count_q <= '0;
            busy_q         <= 1'b0;
            cool_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            irq_q          <= irq_d;
            flush_req_q    <= flush_req_d;
            flush_index_q  <= flush_index_d;
            cpu_stall_q    <= cpu_stall_d;
            alarm_q        <= alarm_d;
            attack_count_q <= attack_count_d;
            busy_q         <= busy_d;
            cool_cnt_q     <= cool_cnt_d;
        end
    end

`ifdef SEC_TARGETED_FLUSH_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end
`endif

    assign flush_req    = flush_req_q;
    assign flush_index  = flush_index_q;
    assign cpu_stall    = cpu_stall_q;
    assign alarm        = alarm_q;
    assign attack_count = attack_count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cache_attack_response_ctrl.sv
// tb/tb_cache_attack_response_ctrl.sv - scoreboard bench for cache_attack_response_ctrl
module tb_cache_attack_response_ctrl;

    localparam int CA  = 3;
    localparam int TH  = 4;
    localparam int WIN = 1024;
    localparam int CD  = 16;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          irq_in = 1'b0;
    logic [CA-1:0] attack_addr = 3'd5;
    logic          clear_alarm = 1'b0;
    logic          flush_ack = 1'b0;
    logic          flush_req;
    logic [CA-1:0] flush_index;
    logic          cpu_stall;
    logic          alarm;
    logic [CW-1:0] attack_count;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx_q[$];

    always #5 clock = ~clock;

    cache_attack_response_ctrl #(
        .CACHE_ADDR   (CA),
        .THRESHOLD    (TH),
        .WINDOW       (WIN),
        .COOLDOWN_CYC (CD),
        .CNT_W        (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .irq_in       (irq_in),
        .attack_addr  (attack_addr),
        .clear_alarm  (clear_alarm),
        .flush_ack    (flush_ack),
        .flush_req    (flush_req),
        .flush_index  (flush_index),
        .cpu_stall    (cpu_stall),
        .alarm        (alarm),
        .attack_count (attack_count),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        irq_in = 1'b1;
        tick(1);
        irq_in = 1'b0;
    endtask

    task automatic pulses(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            tick(gap);
            pulse();
        end
    endtask

    // Every accepted handshake pops the next expected flush index.
    always @(negedge clock) begin
        if (!reset && flush_req && flush_ack) begin
            if (exp_idx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL handshake_unexpected: got index %0d expected none", flush_index);
            end else begin
                check("handshake_index", 32'(flush_index), 32'(exp_idx_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset state
        tick(2);
        check("rst_flush_req", 32'(flush_req), 0);
        check("rst_cpu_stall", 32'(cpu_stall), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_attack_count", 32'(attack_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_flush_index", 32'(flush_index), 0);
        check("rst_state", 32'(dut.state_q), 0);
        reset = 1'b0;

        // Three pulses, then a fourth after the window wraps: no flush
        pulses(3, 9);
        tick(3);
        check("win_hits_pre_wrap", 32'(dut.u_win.hits_q), 3);
        tick(1060);
        pulse();
        tick(3);
        check("win_hits_after_wrap", 32'(dut.u_win.hits_q), 1);
        check("wrap_no_flush_req", 32'(flush_req), 0);
        check("wrap_no_busy", 32'(busy), 0);
        check("wrap_no_alarm", 32'(alarm), 0);
        check("wrap_attack_count", 32'(attack_count), 4);

        reset = 1'b1;
        #1;
        check("rst2_attack_count", 32'(attack_count), 0);
        tick(1);
        reset = 1'b0;

        // Four pulses in one window: flush after N+1, delayed acks
        pulses(4, 9);
        check("latency_edge_n", 32'(flush_req), 0);
        tick(1);
        check("trig_flush_req", 32'(flush_req), 1);
        check("trig_cpu_stall", 32'(cpu_stall), 1);
        check("trig_busy", 32'(busy), 1);
        check("trig_alarm", 32'(alarm), 1);
        check("trig_flush_index", 32'(flush_index), 0);
        check("trig_attack_count", 32'(attack_count), 4);
        for (int i = 0; i < 8; i++) begin
            exp_idx_q.push_back(i);
            for (int w = 0; w < 5; w++) begin
                irq_in = (i == 2 && w == 1);
                tick(1);
                check("idx_hold", 32'(flush_index), 32'(i));
            end
            irq_in = 1'b0;
            check("req_hold", 32'(flush_req), 1);
            flush_ack = 1'b1;
            tick(1);
            flush_ack = 1'b0;
        end
        check("post_flush_req", 32'(flush_req), 0);
        check("post_cpu_stall", 32'(cpu_stall), 0);
        check("post_busy", 32'(busy), 1);
        check("post_flush_index", 32'(flush_index), 0);
        check("flush_irq_attack_count", 32'(attack_count), 5);
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check("cooldown_cycles", 32'(n), 16);
        check("cooldown_hits_cleared", 32'(dut.u_win.hits_q), 0);
        check("alarm_sticky", 32'(alarm), 1);

        // clear_alarm alone, then clear coinciding with the threshold set
        clear_alarm = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        check("clear_alarm_alone", 32'(alarm), 0);
        for (int i = 0; i < 8; i++) exp_idx_q.push_back(i);
        pulses(3, 5);
        tick(5);
        clear_alarm = 1'b1;
        pulse();
        flush_ack = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        check("set_wins_alarm", 32'(alarm), 1);
        check("tied_first_req", 32'(flush_req), 1);
        check("tied_first_index", 32'(flush_index), 0);
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        flush_ack = 1'b0;
        check("tied_ack_busy_cycles", 32'(n), 24);
        check("tied_all_handshakes", 32'(exp_idx_q.size()), 0);
        check("tied_attack_count", 32'(attack_count), 9);
        clear_alarm = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        check("clear_alarm_later", 32'(alarm), 0);

        // Reset mid-flush at index 3
        pulses(4, 5);
        tick(1);
        for (int i = 0; i < 3; i++) exp_idx_q.push_back(i);
        flush_ack = 1'b1;
        tick(3);
        flush_ack = 1'b0;
        check("mid_flush_index", 32'(flush_index), 3);
        tick(2);
        check("mid_flush_index_hold", 32'(flush_index), 3);
        check("mid_flush_req", 32'(flush_req), 1);
        reset = 1'b1;
        #1;
        check("midrst_flush_req", 32'(flush_req), 0);
        check("midrst_cpu_stall", 32'(cpu_stall), 0);
        check("midrst_state", 32'(dut.state_q), 0);
        check("midrst_attack_count", 32'(attack_count), 0);
        check("midrst_alarm", 32'(alarm), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_flush_index", 32'(flush_index), 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("final_queue_empty", 32'(exp_idx_q.size()), 0);
        check("final_flush_req", 32'(flush_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
